// File: rtl/fetch_decode_if.sv
// Fetch-to-decode handshake bundle: fetch pushes words in, decode pops them out.
// "master" is the fetch/decode environment side; "slave" is the queue.
interface fetch_decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instruction;
  logic [XLEN-1:0] in_address;
  logic [XLEN-1:0] in_next_address;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instruction;
  logic [XLEN-1:0] out_address;
  logic [XLEN-1:0] out_next_address;

  modport master (
    output in_valid, in_instruction, in_address, in_next_address, out_ready,
    input  in_ready, out_valid, out_instruction, out_address, out_next_address
  );

  modport slave (
    input  in_valid, in_instruction, in_address, in_next_address, out_ready,
    output in_ready, out_valid, out_instruction, out_address, out_next_address
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of DEPTH words,
// flushed wholesale on a taken jump/branch.
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  fetch_decode_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_addr  [DEPTH];
  logic [XLEN-1:0] mem_next  [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     cnt;
  logic            push;
  logic            pop;

  // in_ready depends only on registered count, so a full queue refuses a push
  // even while decode pops in the same cycle.
  assign bus.in_ready  = (cnt < FULL);
  assign bus.out_valid = (cnt != '0);
  assign push  = bus.in_valid & bus.in_ready;
  assign pop   = bus.out_valid & bus.out_ready;
  assign count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[wr_ptr] <= bus.in_instruction;
      mem_addr[wr_ptr]  <= bus.in_address;
      mem_next[wr_ptr]  <= bus.in_next_address;
    end
  end

  always_comb begin
    bus.out_instruction  = NOP;
    bus.out_address      = '0;
    bus.out_next_address = '0;
    if (cnt != '0) begin
      bus.out_instruction  = mem_instr[rd_ptr];
      bus.out_address      = mem_addr[rd_ptr];
      bus.out_next_address = mem_next[rd_ptr];
    end
  end
endmodule
